// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of ID-stage hazard inputs and stall/bubble/freeze outputs shared by
// the hazard controller (slave) and the pipeline that feeds it (master).
interface hazard_stall_ctrl_if #(
   parameter int REG_AW = 4,
   parameter int NSRC   = 3,
   parameter int CNT_W  = 16
);
   logic [NSRC*REG_AW-1:0] id_src;
   logic [NSRC-1:0]        id_src_vld;
   logic [REG_AW-1:0]      exe_dest;
   logic                   exe_wb_en;
   logic                   exe_mem_rd;
   logic [REG_AW-1:0]      mem_dest;
   logic                   mem_wb_en;
   logic                   mem_ready;
   logic                   fwd_en;
   logic                   stall;
   logic                   bubble;
   logic                   freeze;
   logic [CNT_W-1:0]       stall_cycles;
   logic [CNT_W-1:0]       freeze_cycles;

   modport master (
      output id_src, id_src_vld, exe_dest, exe_wb_en, exe_mem_rd,
             mem_dest, mem_wb_en, mem_ready, fwd_en,
      input  stall, bubble, freeze, stall_cycles, freeze_cycles
   );

   modport slave (
      input  id_src, id_src_vld, exe_dest, exe_wb_en, exe_mem_rd,
             mem_dest, mem_wb_en, mem_ready, fwd_en,
      output stall, bubble, freeze, stall_cycles, freeze_cycles
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ID-stage RAW/load-use hazard controller with multi-cycle load-use stall and
// memory-wait freeze. Define HAZARD_PERF_CNT_EN to build the perf counters.
module hazard_stall_ctrl #(
   parameter int REG_AW     = 4,
   parameter int NSRC       = 3,
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 16
) (
   input logic               clk,
   input logic               rst,
   hazard_stall_ctrl_if.slave bus
);
   localparam int CW = (LOAD_STALL > 1) ? $clog2(LOAD_STALL + 1) : 1;
   localparam logic [CW-1:0] LU_INIT = CW'(LOAD_STALL - 1);
   localparam logic [CW-1:0] LU_ONE  = CW'(1);

   typedef enum logic [1:0] {IDLE, LU_WAIT} state_t;

   state_t        state;
   logic [CW-1:0] lu_cnt;
   logic          hit_exe;
   logic          hit_mem;
   logic          load_use;
   logic          raw_haz;
   logic          freeze;
   logic          stall;

   always_comb begin
      hit_exe = 1'b0;
      hit_mem = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (bus.id_src_vld[i] && bus.exe_wb_en &&
             (bus.id_src[i*REG_AW +: REG_AW] == bus.exe_dest))
            hit_exe = 1'b1;
         if (bus.id_src_vld[i] && bus.mem_wb_en &&
             (bus.id_src[i*REG_AW +: REG_AW] == bus.mem_dest))
            hit_mem = 1'b1;
      end
   end

   // With forwarding only a load in EXE cannot be bypassed in time.
   assign load_use = hit_exe & bus.exe_mem_rd;
   assign raw_haz  = bus.fwd_en ? load_use : (hit_exe | hit_mem);
   assign freeze   = ~bus.mem_ready & ~rst;
   assign stall    = ~rst & ((state == LU_WAIT) | raw_haz);

   assign bus.freeze = freeze;
   assign bus.stall  = stall;
   assign bus.bubble = stall & ~freeze;

   // The IDLE cycle that detects the load-use is the first stall cycle, so
   // LU_WAIT covers the remaining LOAD_STALL-1; a freeze holds everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         lu_cnt <= '0;
      end else if (!freeze) begin
         case (state)
            IDLE: begin
               if (bus.fwd_en && load_use && (LOAD_STALL > 1)) begin
                  state  <= LU_WAIT;
                  lu_cnt <= LU_INIT;
               end
            end
            LU_WAIT: begin
               lu_cnt <= lu_cnt - LU_ONE;
               if (lu_cnt == LU_ONE)
                  state <= IDLE;
            end
            default: begin
               state  <= IDLE;
               lu_cnt <= '0;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] freeze_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt  <= '0;
         freeze_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
         if (freeze && (freeze_cnt != {CNT_W{1'b1}}))
            freeze_cnt <= freeze_cnt + 1'b1;
      end
   end

   assign bus.stall_cycles  = stall_cnt;
   assign bus.freeze_cycles = freeze_cnt;
`else
   assign bus.stall_cycles  = {CNT_W{1'b0}};
   assign bus.freeze_cycles = {CNT_W{1'b0}};
`endif
endmodule
